mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of data words and addresses.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 256, the number of words in the shared data memory.
REQ-003 SHALL have parameter MAX_BURST, default 4, the maximum number of consecutive granted accesses before ownership is re-arbitrated.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_req_i / dbg_req_i, input, 1 bit each: access requests from the processor port and the debug/loader port.
REQ-007 SHALL have ports cpu_we_i / dbg_we_i, input, 1 bit each: 1 = write, 0 = read.
REQ-008 SHALL have ports cpu_addr_i / dbg_addr_i, input, DATA_WIDTH each: absolute byte address in the data segment.
REQ-009 SHALL have ports cpu_wdata_i / dbg_wdata_i, input, DATA_WIDTH each: write data.
REQ-010 SHALL have ports cpu_gnt_o / dbg_gnt_o, output, 1 bit each: the access is performed this cycle.
REQ-011 SHALL have ports cpu_rvalid_o / dbg_rvalid_o, output, 1 bit each: read data is valid.
REQ-012 SHALL have ports cpu_rdata_o / dbg_rdata_o, output, DATA_WIDTH each: read data.
REQ-013 SHALL have port stall_o, output, 1 bit: freezes the Program_Counter when cpu_req_i=1 and cpu_gnt_o=0.
REQ-014 SHALL have ports mem_we_o / mem_re_o, output, 1 bit each; mem_addr_o, output, DATA_WIDTH; mem_wdata_o, output, DATA_WIDTH; mem_rdata_i, input, DATA_WIDTH: the Data_Memory side.

Function
REQ-015 SHALL implement an FSM with states IDLE, OWN_CPU and OWN_DBG; ownership is held in a register.
REQ-016 In IDLE, SHALL grant nothing and SHALL drive mem_we_o=mem_re_o=0.
REQ-017 From IDLE with a single requester, SHALL enter that requester's OWN state on the next edge.
REQ-018 From IDLE with both requesting, SHALL pick the port that is not last_owner (round-robin).
REQ-019 In an OWN state while the owner's req=1, SHALL assert the owner's gnt_o combinationally.
REQ-020 During such a grant, SHALL route the owner's we/addr/wdata to the memory.
REQ-021 During such a grant, SHALL assert mem_we_o = we and mem_re_o = ~we.
REQ-022 SHALL drive mem_addr_o = addr - 32'h10010000, modulo 2^DATA_WIDTH.
REQ-023 SHALL count each granted access in burst_cnt, which resets to 0 on each ownership change.
REQ-024 SHALL move the owner to IDLE on the next edge when the owner's req=0.
REQ-025 SHALL hand ownership directly to the other port when burst_cnt reaches MAX_BURST-1 on a granted access and the other port is requesting.
REQ-026 SHALL keep ownership and wrap burst_cnt to 0 when burst_cnt reaches MAX_BURST-1 and the other port is not requesting.
REQ-027 SHALL assert the requester's rvalid_o exactly 1 cycle after a granted read, with rdata_o = mem_rdata_i.
REQ-028 SHALL hold the non-addressed rdata_o at 0.
REQ-029 A read response SHALL still be delivered if ownership changes in the cycle after the grant.
REQ-030 SHALL assert stall_o = cpu_req_i & ~cpu_gnt_o; a maximum debug hold of MAX_BURST cycles bounds CPU stall.
REQ-031 SHALL never assert both gnt_o outputs, nor mem_we_o and mem_re_o together.

Reset
REQ-032 On reset low, SHALL immediately set state=IDLE, last_owner=DBG (so the CPU wins the first tie), burst_cnt=0, and the pending-read flags to 0.
REQ-033 Under reset, all outputs SHALL be 0; an in-flight read response is discarded.

Configuration
REQ-034 Macro MEM_ARB_RANGE_CHECK_EN SHALL control range checking.
REQ-035 With MEM_ARB_RANGE_CHECK_EN defined, SHALL add output err_o (1 bit, sticky, cleared only by reset).
REQ-036 With MEM_ARB_RANGE_CHECK_EN defined, a granted access whose offset is >= MEMORY_DEPTH*4 SHALL suppress mem_we_o/mem_re_o, still grant, return rvalid with rdata 0, and set err_o.
REQ-037 Without MEM_ARB_RANGE_CHECK_EN, SHALL have no err_o and forward all offsets unchecked.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the state enum (IDLE/OWN_CPU/OWN_DBG), the owner enum (CPU/DBG) and DATA_BASE = 32'h10010000.
REQ-039 Sub-module rr_select SHALL compute the tie-break winner from the two requests plus last_owner; the FSM and the counters stay in mem_arbiter.

Verification
REQ-040 Scenario: CPU-only read at 0x10010008 -> cycle 1 IDLE→OWN_CPU; cycle 2 cpu_gnt_o=1, mem_addr_o=0x8, mem_re_o=1; cycle 3 cpu_rvalid_o=1, cpu_rdata_o=mem_rdata_i.
REQ-041 Scenario: both ports request continuously after reset, MAX_BURST=4 -> CPU receives 4 grants, then DBG receives 4, alternating; never both gnt_o high.
REQ-042 Scenario: DBG owns and is writing 0xDEADBEEF to 0x10010010 while the CPU requests -> stall_o=1 until handoff; mem_we_o=1, mem_addr_o=0x10; at most 4 stalled grant cycles.
REQ-043 Scenario: reset pulled low mid-burst, one cycle after a granted read -> outputs 0 asynchronously, no rvalid after release, state IDLE.
REQ-044 Scenario: CPU read granted in the same cycle its burst ends and DBG takes over -> cpu_rvalid_o=1 next cycle while dbg_gnt_o=1.
REQ-045 Scenario (MEM_ARB_RANGE_CHECK_EN, MEMORY_DEPTH=256): CPU write to 0x10010400 -> cpu_gnt_o=1, mem_we_o=0, err_o=1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DBG = 2'd2
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } owner_e;

  // Start of the data segment; port addresses are absolute, memory addresses are offsets.
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the arbiter and the data memory.
// master: the arbiter's view; slave: the view of the requesters and memory around it.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req_i,   dbg_req_i;
  logic                  cpu_we_i,    dbg_we_i;
  logic [DATA_WIDTH-1:0] cpu_addr_i,  dbg_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wdata_i, dbg_wdata_i;
  logic                  cpu_gnt_o,   dbg_gnt_o;
  logic                  cpu_rvalid_o, dbg_rvalid_o;
  logic [DATA_WIDTH-1:0] cpu_rdata_o, dbg_rdata_o;
  logic                  stall_o;
  logic                  mem_we_o,    mem_re_o;
  logic [DATA_WIDTH-1:0] mem_addr_o,  mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    input  cpu_req_i, dbg_req_i, cpu_we_i, dbg_we_i,
    input  cpu_addr_i, dbg_addr_i, cpu_wdata_i, dbg_wdata_i,
    output cpu_gnt_o, dbg_gnt_o, cpu_rvalid_o, dbg_rvalid_o,
    output cpu_rdata_o, dbg_rdata_o, stall_o,
    output mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    output cpu_req_i, dbg_req_i, cpu_we_i, dbg_we_i,
    output cpu_addr_i, dbg_addr_i, cpu_wdata_i, dbg_wdata_i,
    input  cpu_gnt_o, dbg_gnt_o, cpu_rvalid_o, dbg_rvalid_o,
    input  cpu_rdata_o, dbg_rdata_o, stall_o,
    input  mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter_rr_select.sv
// Round-robin tie-break: with both ports requesting, the port that did not own last wins.
module rr_select
  import mem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  owner_e last_owner,
  output logic   any_req,
  output owner_e winner
);

  assign any_req = cpu_req | dbg_req;

  always_comb begin
    winner = CPU;
    if (cpu_req && dbg_req) begin
      winner = (last_owner == CPU) ? DBG : CPU;
    end else if (dbg_req) begin
      winner = DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single-ported data memory.
// Optional MEM_ARB_RANGE_CHECK_EN adds a sticky err_o for offsets beyond MEMORY_DEPTH words.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 256,
  parameter int MAX_BURST    = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
`ifdef MEM_ARB_RANGE_CHECK_EN
  ,
  output logic          err_o
`endif
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  state_e                state_q, state_d;
  owner_e                last_owner_q, last_owner_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                  rr_any;
  owner_e                rr_winner;
  logic                  cpu_gnt, dbg_gnt, granted;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wdata, offset;
  logic                  oob;
  logic                  cpu_rd_p1, dbg_rd_p1, oob_p1;

  rr_select u_rr_select (
    .cpu_req    (bus.cpu_req_i),
    .dbg_req    (bus.dbg_req_i),
    .last_owner (last_owner_q),
    .any_req    (rr_any),
    .winner     (rr_winner)
  );

  // Ownership FSM; grants are combinational on the owner's live request.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d      = (rr_winner == CPU) ? OWN_CPU : OWN_DBG;
          last_owner_d = rr_winner;
          burst_cnt_d  = '0;
        end
      end
      OWN_CPU: begin
        if (!bus.cpu_req_i) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          cpu_gnt = 1'b1;
          if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = '0;
            if (bus.dbg_req_i) begin
              state_d      = OWN_DBG;
              last_owner_d = DBG;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end
      OWN_DBG: begin
        if (!bus.dbg_req_i) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          dbg_gnt = 1'b1;
          if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = '0;
            if (bus.cpu_req_i) begin
              state_d      = OWN_CPU;
              last_owner_d = CPU;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign granted   = cpu_gnt | dbg_gnt;
  assign sel_we    = cpu_gnt ? bus.cpu_we_i    : bus.dbg_we_i;
  assign sel_addr  = cpu_gnt ? bus.cpu_addr_i  : bus.dbg_addr_i;
  assign sel_wdata = cpu_gnt ? bus.cpu_wdata_i : bus.dbg_wdata_i;
  assign offset    = sel_addr - DATA_WIDTH'(DATA_BASE);

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam longint unsigned OFFSET_LIMIT = longint'(MEMORY_DEPTH) * 4;
  logic err_q;

  assign oob   = granted && (64'(offset) >= OFFSET_LIMIT);
  assign err_o = err_q | oob;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | oob;
  end
`else
  assign oob = 1'b0;
`endif

  assign bus.cpu_gnt_o   = cpu_gnt;
  assign bus.dbg_gnt_o   = dbg_gnt;
  assign bus.stall_o     = reset & bus.cpu_req_i & ~cpu_gnt;
  assign bus.mem_we_o    = granted &  sel_we & ~oob;
  assign bus.mem_re_o    = granted & ~sel_we & ~oob;
  assign bus.mem_addr_o  = granted ? offset    : '0;
  assign bus.mem_wdata_o = granted ? sel_wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= DBG;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Stage p1: memory returns read data one cycle after the grant, independent of ownership.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rd_p1 <= 1'b0;
      dbg_rd_p1 <= 1'b0;
      oob_p1    <= 1'b0;
    end else begin
      cpu_rd_p1 <= cpu_gnt & ~bus.cpu_we_i;
      dbg_rd_p1 <= dbg_gnt & ~bus.dbg_we_i;
      oob_p1    <= oob;
    end
  end

  assign bus.cpu_rvalid_o = cpu_rd_p1;
  assign bus.dbg_rvalid_o = dbg_rd_p1;
  assign bus.cpu_rdata_o  = (cpu_rd_p1 && !oob_p1) ? bus.mem_rdata_i : '0;
  assign bus.dbg_rdata_o  = (dbg_rd_p1 && !oob_p1) ? bus.mem_rdata_i : '0;

endmodule
